// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns for the status display, bit order {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0100111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b1011000;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                         SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to 7-segment pattern with a blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : SEG_LUT[hex];
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed hex display of PC or captured data, one coherent value per frame.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DATA_W = 16,
  parameter int PC_W   = 5,
  parameter int DIV    = 250000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SEL,
  input  logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] DATA,
  input  logic              DATA_VALID,
  input  logic              FREEZE,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] DIG_EN,
  output logic              TICK
);
  localparam int CW = $clog2(DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, nidx;
  logic run, blank;
  logic [DATA_W-1:0] hold, shadow, nshadow;
  logic [6:0] seg_d;
  assign TICK = cnt == CW'(DIV - 1);
  // the first tick after reset starts a frame at digit 0
  always_comb begin
    nidx = !run || idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    nshadow = nidx == '0 && !FREEZE ? (SEL ? hold : DATA_W'(PC)) : shadow;
  end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign blank = nidx != '0 && (nshadow >> (4 * nidx)) == '0;
`else
  assign blank = 1'b0;
`endif
  seg7_decode u_dec (
    .hex  (nshadow[4*nidx +: 4]),
    .blank(blank),
    .seg  (seg_d)
  );
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      idx    <= '0;
      run    <= 1'b0;
      hold   <= '0;
      shadow <= '0;
      SEG    <= SEG_BLANK;
      DIG_EN <= '0;
    end else begin
      cnt <= TICK ? '0 : cnt + 1'b1;
      if (DATA_VALID) hold <= DATA;
      if (TICK) begin
        idx    <= nidx;
        run    <= 1'b1;
        shadow <= nshadow;
        DIG_EN <= DIGITS'(1) << nidx;
        SEG    <= seg_d;
      end
    end
  end
endmodule
